// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by instruction fetch and the MEM stage.
// One transaction in flight at a time; data wins, fetch is guaranteed a slot after MAX_D_BURST data grants.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req (with stable address/data) until its one-cycle ack;
  // the memory answers each one-cycle mem_en with exactly one mem_ready, earliest the next cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_B    = 4'(MAX_D_BURST);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] burst_cnt;
  logic [7:0] tmo_cnt;
  logic       grant_d;
  logic       grant_i;

  // Data keeps priority until it has taken MAX_D_BURST grants in a row past a waiting fetch.
  always_comb begin
    grant_d = d_req && (!if_req || (burst_cnt < MAX_B));
    grant_i = !grant_d && if_req;
  end

  assign if_stall  = if_req & ~if_ack;
  assign d_stall   = d_req & ~d_ack;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            tmo_cnt   <= '0;
            state     <= WAIT_D;
            if (!if_req)               burst_cnt <= '0;
            else if (burst_cnt != MAX_B) burst_cnt <= burst_cnt + 4'd1;
          end else if (grant_i) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            tmo_cnt   <= '0;
            burst_cnt <= '0;
            state     <= WAIT_I;
          end
        end
        WAIT_I, WAIT_D: begin
          if (mem_ready) begin
            if (state == WAIT_I) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
            state <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: acknowledge with zero data so the pipeline can proceed, and flag it.
            if (state == WAIT_I) begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a request-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_D_BURST = 4;
  localparam int TIMEOUT     = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              err;
  logic [1:0]        state_dbg;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_BURST(MAX_D_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Memory responder and scoreboard
  bit               mem_mute = 1'b0;
  int               lat = 1;
  bit               pend = 1'b0;
  int               cnt = 0;
  logic [DATA_W-1:0] next_resp = '0;
  logic [DATA_W-1:0] exp_q[$];

  // One cycle: outputs are observed and inputs driven at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    mem_ready = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = next_resp;
        exp_q.push_back(next_resp);
        pend = 1'b0;
      end
    end
    if (mem_en && !mem_mute && rst_b) begin
      pend = 1'b1;
      cnt  = lat;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, if_ack, d_ack, err} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {mem_en, mem_we, if_ack, d_ack, err});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if ({if_rdata, d_rdata} !== '0)
      $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata);
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
    else n_pass++;
    if_req = 1'b1;
    #1;
    n_checks++;
    if ({if_stall, d_stall} !== 2'b10)
      $display("FAIL reset_stall: got %b want 10", {if_stall, d_stall});
    else n_pass++;
    if_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_single_fetch();
    exp_q.delete();
    lat = 2;
    next_resp = 32'h2008000A;
    if_addr = 32'h0040_0000;
    if_req = 1'b1;
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h0040_0000})
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=00400000", mem_en, mem_we, mem_addr);
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({if_ack, if_stall} !== 2'b01) $display("FAIL fetch_wait: got ack/stall=%b want 01", {if_ack, if_stall});
    else n_pass++;
    step();
    n_checks++;
    if ({if_ack, d_ack, err, if_stall} !== 4'b1000)
      $display("FAIL fetch_ack: got ack/dack/err/stall=%b want 1000", {if_ack, d_ack, err, if_stall});
    else n_pass++;
    n_checks++;
    if (if_rdata !== 32'h2008000A) $display("FAIL fetch_rdata: got %h want 2008000a", if_rdata);
    else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++;
    if ({if_ack, state_dbg} !== {1'b0, ST_IDLE})
      $display("FAIL fetch_after: got ack=%b state=%0d want ack=0 state=0", if_ack, state_dbg);
    else n_pass++;
  endtask

  task automatic test_store();
    lat = 1;
    next_resp = 32'h0;
    d_we = 1'b1;
    d_addr = 32'h1001_0004;
    d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h1001_0004, 32'hDEAD_BEEF})
      $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h want 1 1 10010004 deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_en, d_ack, if_ack} !== 3'b000)
      $display("FAIL store_ready_cycle: got en/dack/iack=%b want 000", {mem_en, d_ack, if_ack});
    else n_pass++;
    step();
    n_checks++;
    if ({d_ack, if_ack, err} !== 3'b100)
      $display("FAIL store_ack: got dack/iack/err=%b want 100", {d_ack, if_ack, err});
    else n_pass++;
    d_req = 1'b0;
    d_we = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int  grants;
    int  run;
    int  stall_bad;
    bit  exp_d;
    bit  got_d;
    bit  fin;
    grants = 0; run = 0; stall_bad = 0; fin = 1'b0;
    lat = 1;
    if_addr = 32'h0040_0100;
    d_addr = 32'h1001_0100;
    d_we = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      step();
      if (if_stall !== !if_ack) stall_bad++;
      if (mem_en) begin
        exp_d = (run < MAX_D_BURST);
        run = exp_d ? run + 1 : 0;
        got_d = (mem_addr == d_addr);
        n_checks++;
        if (got_d !== exp_d) $display("FAIL burst_order: grant %0d got D=%b want D=%b", grants, got_d, exp_d);
        else n_pass++;
        grants++;
      end
      if (if_ack && grants == 10) begin
        if_req = 1'b0;
        d_req = 1'b0;
        fin = 1'b1;
      end
    end
    n_checks++;
    if (!fin || grants != 10) $display("FAIL burst_count: got %0d grants fin=%b want 10 fin=1", grants, fin);
    else n_pass++;
    n_checks++;
    if (stall_bad != 0) $display("FAIL burst_if_stall: got %0d bad cycles want 0", stall_bad);
    else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    int en_cyc;
    int ack_at;
    int acks;
    int lone_err;
    int stray;
    logic ack_err;
    logic [DATA_W-1:0] ack_rdata;
    acks = 0; lone_err = 0; ack_at = -1; stray = 0; ack_err = 1'b0; ack_rdata = 'x;
    mem_mute = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1001_0200;
    d_req = 1'b1;
    step();
    en_cyc = cyc;
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL tmo_issue: got mem_en=%b want 1", mem_en);
    else n_pass++;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      step();
      if (d_ack) begin
        acks++;
        if (ack_at < 0) begin
          ack_at = cyc; ack_err = err; ack_rdata = d_rdata;
        end
        d_req = 1'b0;
      end else if (err) lone_err++;
    end
    n_checks++;
    if (acks != 1 || lone_err != 0) $display("FAIL tmo_ack_once: got acks=%0d lone_err=%0d want 1/0", acks, lone_err);
    else n_pass++;
    n_checks++;
    if (ack_at - en_cyc != TIMEOUT) $display("FAIL tmo_latency: got %0d want %0d", ack_at - en_cyc, TIMEOUT);
    else n_pass++;
    n_checks++;
    if ({ack_err, ack_rdata} !== {1'b1, 32'h0}) $display("FAIL tmo_err_rdata: got err=%b rdata=%h want 1 0", ack_err, ack_rdata);
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL tmo_state: got %0d want %0d", state_dbg, ST_IDLE);
    else n_pass++;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mem_en || if_ack || d_ack || err) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL tmo_stray_ready: got %0d active cycles want 0", stray);
    else n_pass++;
    mem_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    mem_mute = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1001_0300;
    d_req = 1'b1;
    step();
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL rmid_issue: got mem_en=%b want 1", mem_en);
    else n_pass++;
    step();
    step();
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, if_ack, d_ack, err, mem_addr} !== '0)
      $display("FAIL rmid_async: got en/we/iack/dack/err=%b addr=%h want 0 0",
               {mem_en, mem_we, if_ack, d_ack, err}, mem_addr);
    else n_pass++;
    n_checks++;
    if ({state_dbg, d_stall} !== {ST_IDLE, 1'b1})
      $display("FAIL rmid_state_stall: got state=%0d d_stall=%b want 0 1", state_dbg, d_stall);
    else n_pass++;
    repeat (2) begin
      step();
      if (mem_en || d_ack) seen++;
    end
    mem_mute = 1'b0;
    lat = 1;
    next_resp = 32'hCAFE_0001;
    exp_q.delete();
    rst_b = 1'b1;
    step();
    n_checks++;
    if ({mem_en, mem_addr, seen != 0} !== {1'b1, 32'h1001_0300, 1'b0})
      $display("FAIL rmid_reissue: got en=%b addr=%h acks_in_reset=%0d want 1 10010300 0", mem_en, mem_addr, seen);
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hCAFE_0001}) $display("FAIL rmid_ack: got %b %h want 1 cafe0001", d_ack, d_rdata);
    else n_pass++;
    d_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    int wide;
    bit prev_en;
    bit done;
    pulses = 0; last = -1; wide = 0; prev_en = 1'b0; done = 1'b0;
    exp_q.delete();
    lat = 1;
    d_we = 1'b0;
    d_addr = $urandom;
    d_req = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      next_resp = $urandom;
      step();
      if (mem_en) begin
        if (prev_en) wide++;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 4) $display("FAIL b2b_spacing: got %0d want 4", cyc - last);
          else n_pass++;
        end
        last = cyc;
        pulses++;
      end
      prev_en = mem_en;
      if (d_ack) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_rdata: got %h want (no response queued)", d_rdata);
        else if (d_rdata !== exp_q[0]) $display("FAIL b2b_rdata: got %h want %h", d_rdata, exp_q.pop_front());
        else begin n_pass++; void'(exp_q.pop_front()); end
        d_addr = $urandom;
        if (pulses >= 5) begin
          d_req = 1'b0;
          done = 1'b1;
        end
      end
    end
    n_checks++;
    if (!done || pulses != 5 || wide != 0)
      $display("FAIL b2b_pulses: got pulses=%0d wide=%0d done=%b want 5 0 1", pulses, wide, done);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    int   run;
    bit   busy;
    bit   cur_d;
    bit   cur_read;
    bit   want_d;
    logic [ADDR_W-1:0] e_addr;
    logic              e_we;
    logic [DATA_W-1:0] e_wdata;
    logic [DATA_W-1:0] got;
    run = 0; busy = 1'b0; cur_d = 1'b0; cur_read = 1'b1;
    exp_q.delete();
    if_req = 1'b0;
    d_req = 1'b0;
    for (int c = 0; c < 700; c++) begin
      lat = $urandom_range(1, 4);
      next_resp = $urandom;
      step();
      if (mem_en) begin
        want_d = d_req && (!if_req || run < MAX_D_BURST);
        n_checks++;
        if (busy || !(d_req || if_req))
          $display("FAIL rand_grant_legal: got grant busy=%b reqs=%b%b want idle with a request", busy, if_req, d_req);
        else n_pass++;
        run = (want_d && if_req) ? run + 1 : 0;
        e_addr  = want_d ? d_addr : if_addr;
        e_we    = want_d ? d_we : 1'b0;
        e_wdata = want_d ? d_wdata : '0;
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wdata})
          $display("FAIL rand_issue: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                   mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
        else n_pass++;
        busy = 1'b1;
        cur_d = want_d;
        cur_read = !(want_d && d_we);
      end
      if (if_ack || d_ack) begin
        n_checks++;
        if ({if_ack, d_ack, err, busy} !== {!cur_d, cur_d, 1'b0, 1'b1})
          $display("FAIL rand_ack: got iack/dack/err/busy=%b want %b", {if_ack, d_ack, err, busy},
                   {!cur_d, cur_d, 2'b01});
        else n_pass++;
        got = d_ack ? d_rdata : if_rdata;
        if (cur_read) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL rand_rdata: got %h want (no response queued)", got);
          else if (got !== exp_q[0]) $display("FAIL rand_rdata: got %h want %h", got, exp_q[0]);
          else n_pass++;
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        busy = 1'b0;
        if (cur_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      if (c < 600 && !if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (c < 600 && !d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end
    end
    n_checks++;
    if ({if_req, d_req, busy} !== 3'b000)
      $display("FAIL rand_drain: got if_req/d_req/busy=%b want 000", {if_req, d_req, busy});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
